// File: rtl/xilinx_primitive_pkg.sv
// Shared constants and helpers for the Xilinx primitive wrappers and the
// BRAM-backed FIFO controller.
package xilinx_primitive_pkg;

  // BRAM address ports are 15 bits wide regardless of the configured depth.
  localparam int FIFO_ADDR_PAD = 15;

  function automatic int fifo_lat(input int do_reg);
    return 1 + do_reg;
  endfunction

endpackage

// File: rtl/xilinx_fifo_fwft_buf.sv
// Small register FIFO with first-word-fall-through output; it catches BRAM read
// data so the consumer never sees the BRAM read latency.
module xilinx_fifo_fwft_buf #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] cnt
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_rd    = rd_en & (cnt_reg != '0);
  assign rd_valid = (cnt_reg != '0);
  assign rd_data  = rd_valid ? mem_reg[rd_ptr_reg] : '0;
  assign cnt      = cnt_reg;

  // Storage needs no reset: the head is masked until a slot has been written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_rd) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      cnt_reg <= cnt_reg + CNT_W'(wr_en) - CNT_W'(do_rd);
    end
  end

endmodule

// File: rtl/xilinx_sdp_fifo_ctrl.sv
// Valid/ready streaming FIFO around a simple-dual-port BRAM: the write port follows
// the input stream, the read port is driven by a credit-based prefetcher.
module xilinx_sdp_fifo_ctrl
  import xilinx_primitive_pkg::*;
#(
  parameter int WIDTH     = 36,
  parameter int ADDR_W    = 9,
  parameter int DO_REG    = 0,
  parameter int AF_THRESH = (2 ** ADDR_W) - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [WIDTH-1:0]         S_DATA,
  input  logic                     S_VALID,
  output logic                     S_READY,
  output logic [WIDTH-1:0]         M_DATA,
  output logic                     M_VALID,
  input  logic                     M_READY,
  output logic [ADDR_W+1:0]        COUNT,
  output logic                     ALMOST_FULL,
  output logic                     ALMOST_EMPTY,
  output logic [WIDTH-1:0]         BRAM_DI,
  output logic [FIFO_ADDR_PAD-1:0] BRAM_WRADDR,
  output logic                     BRAM_WREN,
  output logic [7:0]               BRAM_WE,
  output logic [FIFO_ADDR_PAD-1:0] BRAM_RDADDR,
  output logic                     BRAM_RDEN,
  output logic                     BRAM_REGCE,
  output logic                     BRAM_RST,
  input  logic [WIDTH-1:0]         BRAM_DO
);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int LAT    = fifo_lat(DO_REG);
  localparam int BUF_D  = LAT + 1;
  localparam int BUF_CW = $clog2(BUF_D + 1);
  localparam int MEM_W  = ADDR_W + 1;
  localparam int CNT_W  = ADDR_W + 2;

  logic [ADDR_W-1:0] wptr_reg;
  logic [ADDR_W-1:0] rptr_reg;
  logic [MEM_W-1:0]  mem_cnt_reg;
  logic [MEM_W-1:0]  mem_cnt_next;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic [LAT-1:0]    vld_sr_reg;
  logic [LAT-1:0]    vld_sr_next;
  logic [CNT_W-1:0]  inflight_acc [LAT+1];
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  ahead;
  logic [BUF_CW-1:0] buf_cnt;
  logic              s_ready_reg;
  logic              af_reg;
  logic              ae_reg;
  logic              push;
  logic              pop;
  logic              issue;
  logic              buf_valid;

  assign push = S_VALID & s_ready_reg;
  assign pop  = buf_valid & M_READY;

  assign inflight_acc[0] = '0;
  for (genvar gi = 0; gi < LAT; gi++) begin : g_inflight
    assign inflight_acc[gi+1] = inflight_acc[gi] + CNT_W'(vld_sr_reg[gi]);
  end
  assign inflight = inflight_acc[LAT];

  // Words already past the BRAM may never exceed the output buffer depth, so a
  // read is only issued when a slot is guaranteed by the time its data lands.
  assign ahead = CNT_W'(buf_cnt) + inflight;
  assign issue = (mem_cnt_reg != '0) && ((ahead - CNT_W'(pop)) < CNT_W'(BUF_D));

  if (LAT == 1) begin : g_sr1
    assign vld_sr_next = issue;
  end else begin : g_srn
    assign vld_sr_next = {vld_sr_reg[LAT-2:0], issue};
  end

  assign mem_cnt_next = mem_cnt_reg + MEM_W'(push) - MEM_W'(issue);
  assign count_next   = count_reg + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      mem_cnt_reg <= '0;
      count_reg   <= '0;
      vld_sr_reg  <= '0;
      s_ready_reg <= 1'b0;
      af_reg      <= 1'b0;
      ae_reg      <= 1'b1;
    end else begin
      if (push)  wptr_reg <= wptr_reg + ADDR_W'(1);
      if (issue) rptr_reg <= rptr_reg + ADDR_W'(1);
      mem_cnt_reg <= mem_cnt_next;
      count_reg   <= count_next;
      vld_sr_reg  <= vld_sr_next;
      s_ready_reg <= (mem_cnt_next < MEM_W'(DEPTH));
      af_reg      <= (count_next >= CNT_W'(AF_THRESH));
      ae_reg      <= (count_next <= CNT_W'(AE_THRESH));
    end
  end

  xilinx_fifo_fwft_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_D),
    .CNT_W (BUF_CW)
  ) u_out_buf (
    .clk      (CLK),
    .rst_n    (RST_N),
    .wr_en    (vld_sr_reg[LAT-1]),
    .wr_data  (BRAM_DO),
    .rd_en    (M_READY),
    .rd_data  (M_DATA),
    .rd_valid (buf_valid),
    .cnt      (buf_cnt)
  );

  assign M_VALID      = buf_valid;
  assign S_READY      = s_ready_reg;
  assign COUNT        = count_reg;
  assign ALMOST_FULL  = af_reg;
  assign ALMOST_EMPTY = ae_reg;

  assign BRAM_DI     = S_DATA;
  assign BRAM_WREN   = push;
  assign BRAM_WE     = 8'hFF;
  assign BRAM_WRADDR = FIFO_ADDR_PAD'(wptr_reg);
  assign BRAM_RDEN   = issue;
  assign BRAM_RDADDR = FIFO_ADDR_PAD'(rptr_reg);
  // The credit check guarantees buffer space, so the read pipeline never stalls.
  assign BRAM_REGCE  = 1'b1;
  assign BRAM_RST    = 1'b0;

endmodule
